// File: rtl/t_pulse_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t_pulse_debouncer_pkg
// Description : Shared types and helpers for the pushbutton debouncer that
//               feeds the toggle flip-flop. Holds the FSM state encoding and
//               the counter-width sanity helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package t_pulse_debouncer_pkg;

    // Debouncer FSM states. The encoding is fixed so that status decoders
    // elsewhere in the design can rely on it.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_HELD     = 2'd2,
        ST_DB_REL   = 2'd3
    } db_state_e;

    // Larger of two unsigned values.
    function automatic int unsigned max_u(input int unsigned a,
                                          input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // True when 'value' is representable in an unsigned counter of 'width' bits.
    function automatic bit cnt_fits(input int unsigned value,
                                    input int unsigned width);
        if (width >= 32) begin
            return 1'b1;
        end
        return ((value >> width) == 0);
    endfunction

endpackage : t_pulse_debouncer_pkg
`default_nettype wire

// File: rtl/t_pulse_debouncer_sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic two-flop synchronizer for signals asynchronous to clk.
//               A level present on i_d before edge k appears on o_q after
//               edge k+1. Reusable for any asynchronous input in the design.
// Ports       : clk   - sampling clock (rising edge)
//               clr   - asynchronous active-high reset, clears both stages
//               i_d   - asynchronous input bus
//               o_q   - synchronized output bus
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // First stage may go metastable; second stage gives it a full cycle
    // to resolve before anything downstream looks at it.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/t_pulse_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : t_pulse_debouncer
// Description : Turns a raw, bouncing pushbutton level into a clean one-cycle
//               toggle pulse for the T input of the toggle flip-flop, with
//               optional auto-repeat while held and a debounced level output.
// Ports       : clk       - single clock, rising edge
//               clr       - asynchronous active-high reset
//               btn_in    - raw button level, asynchronous, may bounce
//               en        - 1 allows t_out pulses; 0 forces t_out low while
//                           the FSM keeps tracking the button
//               t_out     - registered one-cycle toggle pulse
//               btn_level - debounced button level (1 in HELD / DB_REL)
//               busy      - 1 while a press or release is being debounced
// Parameters  : DB_CYCLES     - stable synchronized cycles to accept a change
//               REPEAT_CYCLES - auto-repeat period in HELD, 0 disables
//               CNT_W         - width of the debounce and repeat counters
// Revision    : 1.0 - initial release
// ============================================================================
module t_pulse_debouncer
    import t_pulse_debouncer_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = 16,
    parameter int unsigned REPEAT_CYCLES = 0,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_in,
    input  logic en,
    output logic t_out,
    output logic btn_level,
    output logic busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam bit C_CFG_OK = (DB_CYCLES >= 1) &&
                              cnt_fits(max_u(DB_CYCLES, REPEAT_CYCLES), CNT_W);

    localparam bit               C_RPT_ON   = (REPEAT_CYCLES > 0);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DB_LAST  = CNT_W'(DB_CYCLES - 1);
    // With auto-repeat disabled the terminal value is never used; keep it at
    // zero rather than letting REPEAT_CYCLES-1 wrap.
    localparam logic [CNT_W-1:0] C_RPT_LAST =
        C_RPT_ON ? CNT_W'(REPEAT_CYCLES - 1) : '0;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic             w_s2;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_rpt;
    logic [CNT_W-1:0] w_rpt_nxt;
    logic             r_t_out;
    logic             w_t_out_nxt;
    logic             r_btn_level;
    logic             w_btn_level_nxt;

    // ------------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------------
    sync_2ff #(
        .WIDTH (1)
    ) u_sync_btn (
        .clk (clk),
        .clr (clr),
        .i_d (btn_in),
        .o_q (w_s2)
    );

    // ------------------------------------------------------------------------
    // FSM state and counter registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_rpt       <= '0;
            r_t_out     <= 1'b0;
            r_btn_level <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rpt       <= w_rpt_nxt;
            r_t_out     <= w_t_out_nxt;
            r_btn_level <= w_btn_level_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state, counter and pulse logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rpt_nxt   = r_rpt;
        w_t_out_nxt = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_s2) begin
                    w_state_nxt = ST_DB_PRESS;
                    w_cnt_nxt   = '0;
                end
            end

            ST_DB_PRESS: begin
                if (!w_s2) begin
                    // Bounce: drop back without a pulse.
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == C_DB_LAST) begin
                    // Press accepted. en is sampled only here, so toggling it
                    // during the debounce window has no effect of its own.
                    w_state_nxt = ST_HELD;
                    w_t_out_nxt = en;
                    w_rpt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            ST_HELD: begin
                if (!w_s2) begin
                    w_state_nxt = ST_DB_REL;
                    w_cnt_nxt   = '0;
                end else if (C_RPT_ON) begin
                    if (r_rpt == C_RPT_LAST) begin
                        w_t_out_nxt = en;
                        w_rpt_nxt   = '0;
                    end else begin
                        w_rpt_nxt = r_rpt + C_ONE;
                    end
                end
            end

            ST_DB_REL: begin
                if (w_s2) begin
                    // Release glitch: resume holding, no new pulse, and the
                    // repeat period restarts from here.
                    w_state_nxt = ST_HELD;
                    w_rpt_nxt   = '0;
                end else if (r_cnt == C_DB_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Level is registered from the next state so it changes on the same
        // edge as the acceptance pulse.
        w_btn_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_DB_REL);
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign t_out     = r_t_out;
    assign btn_level = r_btn_level;
    assign busy      = (r_state == ST_DB_PRESS) || (r_state == ST_DB_REL);

    // ------------------------------------------------------------------------
    // Configuration check: counters too narrow for the requested periods
    // would silently wrap and never reach their terminal values.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_cfg_check
        if (!clr) begin
            assert (C_CFG_OK)
                else $error("t_pulse_debouncer: CNT_W=%0d too small for DB_CYCLES=%0d / REPEAT_CYCLES=%0d",
                            CNT_W, DB_CYCLES, REPEAT_CYCLES);
        end
    end

endmodule : t_pulse_debouncer
`default_nettype wire

// File: tb/tb_t_pulse_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_t_pulse_debouncer
// Description : Self-checking bench for t_pulse_debouncer. Two instances:
//               one without auto-repeat, one with a 5-cycle repeat period.
//               Expected pulse edges are queued when stimulus is driven and
//               compared every cycle against t_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t_pulse_debouncer;

    localparam int DB  = 4;
    localparam int RPT = 5;
    // Button high before edge k -> pulse at edge k+2+DB; driven at negedge
    // with cycle count c, so k = c+1.
    localparam int LAT = DB + 3;

    logic clk    = 1'b0;
    logic clr    = 1'b1;
    logic btn    = 1'b0;
    logic en     = 1'b1;
    logic btn_r  = 1'b0;
    logic en_r   = 1'b1;
    logic t0, lvl0, busy0;
    logic t1, lvl1, busy1;
    logic q_ff   = 1'b0;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    int n_exp0   = 0;
    int exp_q0[$];
    int exp_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    t_pulse_debouncer #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (0),
        .CNT_W         (16)
    ) u_dut (
        .clk       (clk),
        .clr       (clr),
        .btn_in    (btn),
        .en        (en),
        .t_out     (t0),
        .btn_level (lvl0),
        .busy      (busy0)
    );

    t_pulse_debouncer #(
        .DB_CYCLES     (DB),
        .REPEAT_CYCLES (RPT),
        .CNT_W         (16)
    ) u_dut_r (
        .clk       (clk),
        .clr       (clr),
        .btn_in    (btn_r),
        .en        (en_r),
        .t_out     (t1),
        .btn_level (lvl1),
        .busy      (busy1)
    );

    // Downstream toggle flip-flop driven by the debouncer.
    always @(posedge clk or posedge clr) begin
        if (clr) q_ff <= 1'b0;
        else if (t0) q_ff <= ~q_ff;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
    endtask

    // Scoreboards: pop an expected pulse edge when it arrives, compare t_out
    // every cycle.
    always @(negedge clk) begin : p_mon0
        bit want;
        want = 1'b0;
        while (exp_q0.size() > 0 && exp_q0[0] < cyc) begin
            n_checks++;
            $display("FAIL sb0_stale @cyc %0d: got entry %0d expected none", cyc, exp_q0[0]);
            void'(exp_q0.pop_front());
        end
        if (exp_q0.size() > 0 && exp_q0[0] == cyc) begin
            want = 1'b1;
            void'(exp_q0.pop_front());
        end
        chk("t_out0", {31'd0, t0}, {31'd0, want});
    end

    always @(negedge clk) begin : p_mon1
        bit want;
        want = 1'b0;
        while (exp_q1.size() > 0 && exp_q1[0] < cyc) begin
            n_checks++;
            $display("FAIL sb1_stale @cyc %0d: got entry %0d expected none", cyc, exp_q1[0]);
            void'(exp_q1.pop_front());
        end
        if (exp_q1.size() > 0 && exp_q1[0] == cyc) begin
            want = 1'b1;
            void'(exp_q1.pop_front());
        end
        chk("t_out1", {31'd0, t1}, {31'd0, want});
    end

    task automatic push0(input int edge_no);
        exp_q0.push_back(edge_no);
        n_exp0++;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        int hi;          // cycles btn_in held high
        bit en;          // en during the press
        bit exp_pulse;   // pulse expected at acceptance edge
        bit exp_lvl;     // btn_level at acceptance edge
        bit exp_busy;    // busy one cycle after DB_PRESS entry
    } vec_t;

    vec_t vec[9];

    initial begin : p_main
        int c;
        int a;

        vec[0] = '{1,  1'b1, 1'b0, 1'b0, 1'b0};
        vec[1] = '{3,  1'b1, 1'b0, 1'b0, 1'b1};
        vec[2] = '{4,  1'b1, 1'b0, 1'b0, 1'b1};
        vec[3] = '{5,  1'b1, 1'b1, 1'b1, 1'b1};
        vec[4] = '{8,  1'b1, 1'b1, 1'b1, 1'b1};
        vec[5] = '{20, 1'b1, 1'b1, 1'b1, 1'b1};
        vec[6] = '{10, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[7] = '{6,  1'b0, 1'b0, 1'b1, 1'b1};
        vec[8] = '{2,  1'b1, 1'b0, 1'b0, 1'b1};

        // ---- 1: reset held with button high ----
        btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_t_out",  {31'd0, t0},    0);
            chk("rst_level",  {31'd0, lvl0},  0);
            chk("rst_busy",   {31'd0, busy0}, 0);
            chk("rst_busy_r", {31'd0, busy1}, 0);
        end
        c = cyc;
        clr = 1'b0;
        push0(c + LAT);
        wait_cyc(LAT);
        chk("post_rst_level", {31'd0, lvl0}, 1);
        wait_cyc(5);
        btn = 1'b0;
        wait_cyc(12);
        chk("post_rst_idle_level", {31'd0, lvl0}, 0);

        // ---- 2: table of single presses of varying length / en ----
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            c = cyc;
            a = c + LAT;
            btn = 1'b1;
            en  = vec[i].en;
            if (vec[i].exp_pulse) push0(a);
            for (int j = 1; j <= vec[i].hi + 10; j++) begin
                @(negedge clk);
                if (j == vec[i].hi) btn = 1'b0;
                if (cyc == c + 4) chk("vec_busy", {31'd0, busy0}, {31'd0, vec[i].exp_busy});
                if (cyc == a)     chk("vec_level", {31'd0, lvl0}, {31'd0, vec[i].exp_lvl});
            end
            chk("vec_end_level", {31'd0, lvl0},  0);
            chk("vec_end_busy",  {31'd0, busy0}, 0);
        end
        en = 1'b1;

        // ---- 3: bounce 1-0-1-0 then stable high ----
        for (int i = 0; i < 2; i++) begin
            btn = 1'b1; wait_cyc(2);
            btn = 1'b0; wait_cyc(2);
        end
        c = cyc;
        btn = 1'b1;
        push0(c + LAT);
        wait_cyc(LAT - 1);
        chk("bounce_level_pre", {31'd0, lvl0}, 0);
        wait_cyc(4);
        btn = 1'b0;
        wait_cyc(12);

        // ---- 4: release glitch inside HELD ----
        c = cyc;
        btn = 1'b1;
        push0(c + LAT);
        wait_cyc(12);
        btn = 1'b0;
        wait_cyc(2);
        btn = 1'b1;
        wait_cyc(1);
        chk("glitch_busy_rel",  {31'd0, busy0}, 1);
        chk("glitch_level_rel", {31'd0, lvl0},  1);
        wait_cyc(2);
        chk("glitch_busy_held", {31'd0, busy0}, 0);
        chk("glitch_level",     {31'd0, lvl0},  1);
        wait_cyc(7);
        btn = 1'b0;
        wait_cyc(12);

        // ---- en changed mid-press: only the accepting edge counts ----
        c = cyc;
        btn = 1'b1; en = 1'b0;
        push0(c + LAT);
        wait_cyc(LAT - 1);
        en = 1'b1;
        wait_cyc(5);
        btn = 1'b0;
        wait_cyc(12);
        c = cyc;
        btn = 1'b1; en = 1'b1;
        wait_cyc(LAT - 1);
        en = 1'b0;
        wait_cyc(5);
        btn = 1'b0; en = 1'b1;
        wait_cyc(12);

        // ---- 5: auto-repeat instance ----
        c = cyc;
        btn_r = 1'b1; en_r = 1'b1;
        for (int m = 0; m < 6; m++) exp_q1.push_back(c + LAT + m * RPT);
        wait_cyc(32);
        chk("rpt_level", {31'd0, lvl1}, 1);
        btn_r = 1'b0;
        wait_cyc(15);
        chk("rpt_level_rel", {31'd0, lvl1}, 0);
        c = cyc;
        btn_r = 1'b1; en_r = 1'b0;
        wait_cyc(20);
        chk("rpt_en0_level", {31'd0, lvl1}, 1);
        wait_cyc(12);
        btn_r = 1'b0; en_r = 1'b1;
        wait_cyc(15);

        // ---- 6: reset mid-debounce, flip-flop parity ----
        chk("ff_parity", {31'd0, q_ff}, {31'd0, n_exp0[0]});
        c = cyc;
        btn = 1'b1;
        wait_cyc(5);
        chk("clr_busy_before", {31'd0, busy0}, 1);
        clr = 1'b1;
        btn = 1'b0;
        #1;
        chk("clr_busy",  {31'd0, busy0}, 0);
        chk("clr_t_out", {31'd0, t0},    0);
        chk("clr_level", {31'd0, lvl0},  0);
        wait_cyc(2);
        clr = 1'b0;
        wait_cyc(2);
        c = cyc;
        btn = 1'b1;
        push0(c + LAT);
        wait_cyc(10);
        btn = 1'b0;
        wait_cyc(12);
        chk("ff_after_clr", {31'd0, q_ff}, 1);

        chk("sb0_drained", exp_q0.size(), 0);
        chk("sb1_drained", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_t_pulse_debouncer
`default_nettype wire
